// File: rtl/inj_ctrl.sv
// inj_ctrl: local injection FIFO and starvation monitor for a NoC router port.
// Buffers flits offered by the local core. It injects the head flit whenever at
// least one post-ejection link slot is free. It flags starvation when the head
// has been blocked for STARVE_LIMIT consecutive cycles.
//
// Ports
//   clk, rst      : single clock, synchronous active-high reset
//   core_flit     : flit from the core; bit 9 is forced to 1 when stored
//   core_valid    : core offers core_flit this cycle
//   core_ready    : FIFO not full (from registered occupancy)
//   link_busy     : {w,e,s,n} link-slot valid bits; all ones blocks injection
//   lin           : head flit while inj_fire, else zero
//   inj_fire      : head flit is injected (and popped) this cycle
//   starve        : head has been starved; throttles neighbours
//   occupancy     : current FIFO count, 0..DEPTH
module inj_ctrl #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  core_flit,
    input  logic        core_valid,
    output logic        core_ready,
    input  logic [3:0]  link_busy,
    output logic [9:0]  lin,
    output logic        inj_fire,
    output logic        starve,
    output logic [4:0]  occupancy
);

    localparam int unsigned FLIT_W = 10;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned WAIT_W = 8;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [FLIT_W-1:0] VALID_BIT = FLIT_W'(10'h200);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STARVE
    } state_e;

    state_e                state_q, state_d;
    logic [FLIT_W-1:0]     mem_q [DEPTH];
    logic [FLIT_W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  push;
    logic                  pop;
    logic                  not_full;
    logic                  last_out;

    // Port-facing decode; reset forces the documented idle values immediately.
    always_comb begin
        not_full   = (count_q < CNT_W'(DEPTH));
        core_ready = rst || not_full;
        inj_fire   = !rst && (count_q != '0) && (link_busy != 4'b1111);
        lin        = inj_fire ? mem_q[rd_ptr_q] : '0;
        starve     = !rst && (state_q == STARVE);
        occupancy  = rst ? '0 : count_q;
        // Fullness is judged on registered state, so a same-cycle pop never frees a slot.
        push       = !rst && core_valid && not_full;
        pop        = inj_fire;
        last_out   = pop && !push && (count_q == CNT_W'(1));
    end

    // FIFO, blocked-head counter and starvation FSM next state.
    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        wait_cnt_d = wait_cnt_q;
        state_d    = state_q;

        if (push) begin
            mem_d[wr_ptr_q] = core_flit | VALID_BIT;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if ((count_q == '0) || pop) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_W'(STARVE_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        // Entering STARVE on the edge where wait_cnt reaches the limit makes
        // starve visible in the same cycle as the saturated count.
        unique case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (last_out) begin
                    state_d = IDLE;
                end else if (wait_cnt_d == WAIT_W'(STARVE_LIMIT)) begin
                    state_d = STARVE;
                end
            end
            STARVE: begin
                if (last_out) begin
                    state_d = IDLE;
                end else if (pop) begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_inj_ctrl.sv
// tb_inj_ctrl: scoreboard bench for inj_ctrl with directed and random traffic.
module tb_inj_ctrl;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic       clk;
    logic       rst;
    logic [9:0] core_flit;
    logic       core_valid;
    logic       core_ready;
    logic [3:0] link_busy;
    logic [9:0] lin;
    logic       inj_fire;
    logic       starve;
    logic [4:0] occupancy;

    inj_ctrl #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_flit  (core_flit),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .link_busy  (link_busy),
        .lin        (lin),
        .inj_fire   (inj_fire),
        .starve     (starve),
        .occupancy  (occupancy)
    );

    typedef struct packed {
        logic       ready;
        logic       fire;
        logic       starve;
        logic [4:0] occ;
    } ctl_t;

    ctl_t       ctl_q[$];
    logic [9:0] exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;

    // Reference model: queue length and length of the current blocked run.
    int         m_cnt    = 0;
    int         m_streak = 0;
    logic       pend_v   = 1'b0;
    logic [9:0] pend_f   = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard.
    always @(negedge clk) begin
        ctl_t e;
        if (ctl_q.size() != 0) begin
            e = ctl_q.pop_front();
            check("core_ready", int'(core_ready), int'(e.ready));
            check("inj_fire", int'(inj_fire), int'(e.fire));
            check("starve", int'(starve), int'(e.starve));
            check("occupancy", int'(occupancy), int'(e.occ));
            if (e.fire) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL lin_order: got %0h with no flit expected at %0t", lin, $time);
                end else begin
                    check("lin_flit", int'(lin), int'(exp_q.pop_front()));
                end
            end else begin
                check("lin_idle", int'(lin), 0);
            end
        end
    end

    // One clock cycle of stimulus; records the expected response for the monitor.
    task automatic step(input logic r, input logic v, input logic [9:0] f, input logic [3:0] b);
        ctl_t e;
        logic fire;
        logic push;
        // A flit accepted last cycle is now in the FIFO.
        if (pend_v) begin
            exp_q.push_back(pend_f);
            pend_v = 1'b0;
        end
        rst        = r;
        core_valid = v;
        core_flit  = f;
        link_busy  = b;
        if (r) begin
            exp_q.delete();
            e.ready  = 1'b1;
            e.fire   = 1'b0;
            e.starve = 1'b0;
            e.occ    = 5'd0;
            m_cnt    = 0;
            m_streak = 0;
        end else begin
            fire     = (m_cnt != 0) && (b != 4'b1111);
            push     = v && (m_cnt < DEPTH);
            e.ready  = (m_cnt < DEPTH);
            e.fire   = fire;
            e.starve = (m_streak >= LIMIT);
            e.occ    = 5'(m_cnt);
            if (push) begin
                pend_v = 1'b1;
                pend_f = f | 10'h200;
            end
            if ((m_cnt != 0) && !fire) begin
                if (m_streak < LIMIT) m_streak = m_streak + 1;
            end else begin
                m_streak = 0;
            end
            m_cnt = m_cnt + int'(push) - int'(fire);
        end
        ctl_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [3:0] b);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'h000, b);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && m_cnt != 0; i++) step(1'b0, 1'b0, 10'h000, 4'b0000);
    endtask

    initial begin
        rst        = 1'b1;
        core_valid = 1'b0;
        core_flit  = '0;
        link_busy  = 4'b1111;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 10'h000, 4'b1111);
        step(1'b1, 1'b0, 10'h000, 4'b1111);
        idle(2, 4'b1111);

        // Blocked head released by one free link.
        step(1'b0, 1'b1, 10'h005, 4'b1111);
        idle(2, 4'b1111);
        idle(1, 4'b0111);
        idle(2, 4'b0000);

        // Bit 9 of the stored flit is forced high.
        step(1'b0, 1'b1, 10'h0AA, 4'b0000);
        idle(2, 4'b0000);

        // Overfill with all links busy: fifth push refused.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 10'(10'h010 + i), 4'b1111);
        drain();

        // Starvation after LIMIT blocked cycles, cleared after the next injection.
        step(1'b0, 1'b1, 10'h123, 4'b1111);
        step(1'b0, 1'b1, 10'h124, 4'b1111);
        idle(10, 4'b1111);
        idle(1, 4'b1110);
        idle(2, 4'b1111);
        drain();

        // Steady push and pop at occupancy 2 preserves order.
        step(1'b0, 1'b1, 10'h301, 4'b1111);
        step(1'b0, 1'b1, 10'h302, 4'b1111);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 10'($urandom_range(0, 1023)), 4'b0000);
        drain();

        // Reset while starving with three flits queued.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10'(10'h040 + i), 4'b1111);
        idle(10, 4'b1111);
        step(1'b1, 1'b1, 10'h155, 4'b0000);
        idle(3, 4'b0000);

        // Random traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] b;
            b = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 6),
                 10'($urandom_range(0, 1023)), b);
        end
        drain();
        idle(2, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inj_ctrl.md
INJ_CTRL -- requirements
Module: inj_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4: local injection FIFO depth in flits; power of two, 2..16.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: consecutive blocked-head cycles before starvation is declared; range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port core_flit, input, 10: flit from local core; bit 9 is valid, bits 8:0 are address/payload.
REQ-006 SHALL have port core_valid, input, 1: core offers core_flit this cycle.
REQ-007 SHALL have port core_ready, output, 1: FIFO can accept a flit this cycle.
REQ-008 SHALL have port link_busy, input, 4: {w,e,s,n} valid bits of the post-ejection link flits feeding the injector.
REQ-009 SHALL have port lin, output, 10: local flit to injector; all-zero when nothing is injected.
REQ-010 SHALL have port inj_fire, output, 1: a flit is driven on lin this cycle.
REQ-011 SHALL have port starve, output, 1: head flit is starved; throttles neighbours.
REQ-012 SHALL have port occupancy, output, 5: current FIFO count, 0..DEPTH.

Function
REQ-013 SHALL accept a flit when core_valid && core_ready; the stored flit bit 9 SHALL be forced to 1.
REQ-014 SHALL drive core_ready = (occupancy < DEPTH), from registered state only; a push is refused when full even if a pop occurs in the same cycle.
REQ-015 SHALL drive inj_fire = (occupancy != 0) && (link_busy != 4'b1111), combinational from registered state and link_busy.
REQ-016 SHALL drive lin = FIFO head when inj_fire, else 10'h000; zero-latency from the head register.
REQ-017 SHALL pop the head at the clock edge ending each inj_fire cycle.
REQ-018 SHALL allow a flit pushed in cycle N to be injected no earlier than cycle N+1.
REQ-019 SHALL handle simultaneous push and pop with occupancy unchanged and correct FIFO order.
REQ-020 SHALL wrap read and write pointers modulo DEPTH.
REQ-021 SHALL keep wait_cnt, width 8: increment when occupancy != 0 and !inj_fire, saturate at STARVE_LIMIT, clear on inj_fire or when occupancy == 0.
REQ-022 SHALL implement an FSM with states IDLE, WAIT and STARVE.
REQ-023 SHALL move IDLE->WAIT on the first push.
REQ-024 SHALL move WAIT->STARVE when wait_cnt reaches STARVE_LIMIT.
REQ-025 SHALL move WAIT or STARVE->IDLE when a pop leaves the FIFO empty with no push.
REQ-026 SHALL move STARVE->WAIT on inj_fire when flits remain.
REQ-027 SHALL drive starve = 1 only in STARVE; registered, so it asserts the cycle after wait_cnt reaches STARVE_LIMIT.
REQ-028 SHALL preserve FIFO order; no flit is dropped or duplicated.

Reset
REQ-029 SHALL on rst clear the pointers, occupancy, wait_cnt and FIFO contents, and put the FSM in IDLE.
REQ-030 SHALL hold these outputs while rst is high and in the first cycle after: core_ready=1, inj_fire=0, lin=0, starve=0, occupancy=0.
REQ-031 SHALL give rst priority over a push or pop in the same cycle; flits in flight are discarded and nothing injects that cycle.

Verification
REQ-032 SHALL cover this case: push 10'h005 with link_busy=4'b1111 for 3 cycles, then 4'b0111 -> lin=10'h205 and inj_fire=1 in that cycle, occupancy 1->0.
REQ-033 SHALL cover this case: 5 back-to-back pushes with DEPTH=4 and links all busy -> core_ready=0 after the 4th; 5th refused; occupancy=4.
REQ-034 SHALL cover this case: links all busy for 8 cycles with a head present -> starve=1 on cycle 9; first free link -> inj_fire=1, then starve=0 next cycle.
REQ-035 SHALL cover this case: push and pop in the same cycle at occupancy 2 -> occupancy stays 2; output order equals input order over 20 random flits.
REQ-036 SHALL cover this case: rst asserted with occupancy 3 in STARVE -> next cycle occupancy=0, starve=0, lin=0, core_ready=1.
REQ-037 SHALL cover this case: core_flit=10'h0AA (bit 9 low) pushed -> injected as 10'h2AA.
